// File: rtl/match_controller.sv
// Pong match sequencer: owns the match FSM, both score counters, serve timing and key edge detection.
// Optional pause support is compiled in when MATCH_PAUSE_EN is defined.
module match_controller #(
    parameter int KEYS_W       = 4,
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30,
    parameter int SCORE_W      = $clog2(WIN_SCORE + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [KEYS_W-1:0]  keys_i,
    input  logic               new_frame_i,
    input  logic               player_goal_i,
    input  logic               enemy_goal_i,
    output logic               run_o,
    output logic               serve_o,
    output logic               serve_dir_o,
    output logic [SCORE_W-1:0] player_score_o,
    output logic [SCORE_W-1:0] enemy_score_o,
    output logic               game_over_o,
    output logic               winner_o,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4,
        PAUSE = 3'd5
    } state_t;

    localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   frame_cnt_q;
    logic [SCORE_W-1:0] player_score_q, enemy_score_q;
    logic               serve_dir_q, winner_q, serve_q, run_q;
    logic               run_d, serve_d;
    logic               start_edge, start_take, expire;
    logic               player_wins, enemy_wins;
    logic               unused_keys;

    assign unused_keys = ^keys_i;

`ifdef MATCH_PAUSE_EN
    logic [1:0] key_q;
    logic       pause_edge;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) key_q <= '0;
        else         key_q <= keys_i[3:2];
    end

    assign start_edge = keys_i[2] & ~key_q[0];
    assign pause_edge = keys_i[3] & ~key_q[1];
`else
    logic key_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) key_q <= 1'b0;
        else         key_q <= keys_i[2];
    end

    assign start_edge = keys_i[2] & ~key_q;
`endif

    assign start_take  = start_edge && (state_q == IDLE || state_q == OVER);
    assign expire      = new_frame_i && (frame_cnt_q == CNT_ONE);
    assign player_wins = (player_score_q + SCORE_ONE) == WIN_VAL;
    assign enemy_wins  = (enemy_score_q + SCORE_ONE) == WIN_VAL;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_edge) state_d = SERVE;
            SERVE: if (expire)     state_d = PLAY;
            PLAY: begin
                if (player_goal_i && enemy_goal_i) state_d = POINT;
                else if (player_goal_i)            state_d = player_wins ? OVER : POINT;
                else if (enemy_goal_i)             state_d = enemy_wins ? OVER : POINT;
`ifdef MATCH_PAUSE_EN
                else if (pause_edge)               state_d = PAUSE;
`endif
            end
            POINT: if (expire)     state_d = SERVE;
            OVER:  if (start_edge) state_d = SERVE;
`ifdef MATCH_PAUSE_EN
            PAUSE: if (pause_edge) state_d = PLAY;
`endif
            default: state_d = IDLE;
        endcase
    end

    // run_o waits one cycle after PLAY entry but drops on the same edge PLAY is left.
    always_comb begin
        run_d   = (state_q == PLAY) && (state_d == PLAY);
        serve_d = (state_q == SERVE) && expire;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q    <= '0;
            player_score_q <= '0;
            enemy_score_q  <= '0;
            serve_dir_q    <= 1'b0;
            winner_q       <= 1'b0;
            serve_q        <= 1'b0;
            run_q          <= 1'b0;
        end else begin
            serve_q <= serve_d;
            run_q   <= run_d;

            // Load on entry wins over a same-cycle frame strobe.
            if (state_d == SERVE && state_q != SERVE)      frame_cnt_q <= SERVE_LOAD;
            else if (state_d == POINT && state_q != POINT) frame_cnt_q <= POINT_LOAD;
            else if (new_frame_i && frame_cnt_q != '0)     frame_cnt_q <= frame_cnt_q - CNT_ONE;

            if (start_take) begin
                player_score_q <= '0;
                enemy_score_q  <= '0;
                serve_dir_q    <= 1'b0;
                winner_q       <= 1'b0;
            end else if (state_q == PLAY && player_goal_i && !enemy_goal_i) begin
                player_score_q <= player_score_q + SCORE_ONE;
                serve_dir_q    <= 1'b0;
                if (player_wins) winner_q <= 1'b1;
            end else if (state_q == PLAY && enemy_goal_i && !player_goal_i) begin
                enemy_score_q <= enemy_score_q + SCORE_ONE;
                serve_dir_q   <= 1'b1;
                if (enemy_wins) winner_q <= 1'b0;
            end
        end
    end

    assign run_o          = run_q;
    assign serve_o        = serve_q;
    assign serve_dir_o    = serve_dir_q;
    assign player_score_o = player_score_q;
    assign enemy_score_o  = enemy_score_q;
    assign game_over_o    = (state_q == OVER);
    assign winner_o       = winner_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_match_controller.sv
// Testbench for match_controller: directed match scenarios followed by random play, all checked
// against a cycle-level behavioural model of the match rules. Honours MATCH_PAUSE_EN.
module tb_match_controller;

    localparam int SERVE_N = 3;
    localparam int POINT_N = 2;
    localparam int WIN_N   = 2;
    localparam int SW      = $clog2(WIN_N + 1);

    logic          clk;
    logic          rst_n;
    logic [3:0]    keys;
    logic          new_frame, player_goal, enemy_goal;
    logic          run, serve, serve_dir, game_over, winner;
    logic [SW-1:0] player_score, enemy_score;
    logic [2:0]    state;

    int n_cmp  = 0;
    int n_fail = 0;
    int serve_seen;

    // Model of the match: state codes as seen on state_o, frames still to wait, scores, flags.
    int m_st, m_left, m_ps, m_es, m_play_age;
    bit m_dir, m_win, m_serve, m_run, m_prev_start, m_prev_pause;

    match_controller #(
        .KEYS_W(4), .WIN_SCORE(WIN_N), .SERVE_FRAMES(SERVE_N), .POINT_FRAMES(POINT_N)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .keys_i(keys), .new_frame_i(new_frame),
        .player_goal_i(player_goal), .enemy_goal_i(enemy_goal),
        .run_o(run), .serve_o(serve), .serve_dir_o(serve_dir),
        .player_score_o(player_score), .enemy_score_o(enemy_score),
        .game_over_o(game_over), .winner_o(winner), .state_o(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_st = 0; m_left = 0; m_ps = 0; m_es = 0; m_play_age = 0;
        m_dir = 0; m_win = 0; m_serve = 0; m_run = 0;
        m_prev_start = 0; m_prev_pause = 0;
    endfunction

    function automatic void model_step(input logic [3:0] k, input logic f, input logic pg, input logic eg);
        bit se, pe;
        int nst;
        se = k[2] && !m_prev_start;
`ifdef MATCH_PAUSE_EN
        pe = k[3] && !m_prev_pause;
`else
        pe = 1'b0;
`endif
        nst = m_st;
        m_serve = 0;
        case (m_st)
            0, 4: if (se) begin
                nst = 1; m_ps = 0; m_es = 0; m_dir = 0; m_win = 0; m_left = SERVE_N;
            end
            1: if (f) begin
                m_left--;
                if (m_left == 0) begin nst = 2; m_serve = 1; end
            end
            2: begin
                if (pg && eg) begin
                    nst = 3; m_left = POINT_N;
                end else if (pg || eg) begin
                    if (pg) begin m_ps++; m_dir = 0; end
                    else    begin m_es++; m_dir = 1; end
                    if ((pg ? m_ps : m_es) == WIN_N) begin nst = 4; m_win = pg; end
                    else begin nst = 3; m_left = POINT_N; end
                end else if (pe) begin
                    nst = 5;
                end
            end
            3: if (f) begin
                m_left--;
                if (m_left == 0) begin nst = 1; m_left = SERVE_N; end
            end
            5: if (pe) nst = 2;
            default: nst = 0;
        endcase
        // The datapath runs from the second cycle spent in PLAY onward.
        m_play_age   = (nst == 2 && m_st == 2) ? m_play_age + 1 : 0;
        m_run        = (nst == 2) && (m_play_age >= 1);
        m_st         = nst;
        m_prev_start = k[2];
        m_prev_pause = k[3];
    endfunction

    task automatic check_all();
        check("state",  state,        m_st);
        check("run",    run,          m_run);
        check("serve",  serve,        m_serve);
        check("dir",    serve_dir,    m_dir);
        check("pscore", player_score, m_ps);
        check("escore", enemy_score,  m_es);
        check("over",   game_over,    (m_st == 4));
        check("winner", winner,       m_win);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"},  state,        0);
        check({tag, "_run"},    run,          0);
        check({tag, "_serve"},  serve,        0);
        check({tag, "_dir"},    serve_dir,    0);
        check({tag, "_pscore"}, player_score, 0);
        check({tag, "_escore"}, enemy_score,  0);
        check({tag, "_over"},   game_over,    0);
        check({tag, "_winner"}, winner,       0);
    endtask

    task automatic tick(input logic [3:0] k, input logic f, input logic pg, input logic eg);
        keys = k; new_frame = f; player_goal = pg; enemy_goal = eg;
        model_step(k, f, pg, eg);
        @(posedge clk);
        #1;
        if (serve === 1'b1) serve_seen++;
        check_all();
    endtask

    // Strobe frames until the model reaches PLAY (bounded).
    task automatic go_play();
        for (int i = 0; i < 12 && m_st != 2; i++) tick(4'h0, 1'b1, 1'b0, 1'b0);
        tick(4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        keys = '0; new_frame = 1'b0; player_goal = 1'b0; enemy_goal = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        keys = '0; new_frame = 1'b0; player_goal = 1'b0; enemy_goal = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Idle with no keys: frames and goals must not move anything.
        for (int i = 0; i < 100; i++)
            tick(4'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("idle_state", state, 0);

        // Start held for 20 cycles: one SERVE entry, one serve pulse after the 3rd frame.
        serve_seen = 0;
        tick(4'h4, 1'b0, 1'b0, 1'b0);
        check("serve_entry", state, 1);
        tick(4'h4, 1'b1, 1'b0, 1'b0);
        tick(4'h4, 1'b0, 1'b0, 1'b0);
        tick(4'h4, 1'b1, 1'b0, 1'b0);
        check("serve_wait", serve, 0);
        tick(4'h4, 1'b1, 1'b0, 1'b0);
        check("serve_pulse", serve, 1);
        check("play_entry", state, 2);
        check("run_entry", run, 0);
        tick(4'h4, 1'b0, 1'b0, 1'b0);
        check("run_rise", run, 1);
        check("serve_drop", serve, 0);
        for (int i = 0; i < 14; i++) tick(4'h4, 1'b0, 1'b0, 1'b0);
        check("serve_once", serve_seen, 1);

        // Scoring and serve direction.
        tick(4'h0, 1'b0, 1'b1, 1'b0);
        check("pgoal_score", player_score, 1);
        check("pgoal_dir", serve_dir, 0);
        check("pgoal_state", state, 3);
        tick(4'h0, 1'b1, 1'b0, 1'b0);
        check("point_hold", state, 3);
        tick(4'h0, 1'b1, 1'b0, 1'b0);
        check("point_exit", state, 1);
        go_play();
        tick(4'h0, 1'b0, 1'b0, 1'b1);
        check("egoal_score", enemy_score, 1);
        check("egoal_dir", serve_dir, 1);

        // Simultaneous goals replay the point; goals during SERVE are ignored.
        go_play();
        tick(4'h0, 1'b0, 1'b1, 1'b1);
        check("both_state", state, 3);
        check("both_pscore", player_score, 1);
        check("both_escore", enemy_score, 1);
        tick(4'h0, 1'b1, 1'b0, 1'b0);
        tick(4'h0, 1'b1, 1'b0, 1'b0);
        tick(4'h0, 1'b0, 1'b0, 1'b1);
        check("serve_goal_ign", enemy_score, 1);
        tick(4'h0, 1'b1, 1'b1, 1'b0);
        check("serve_goal_ign2", player_score, 1);
        go_play();

        // Asynchronous reset mid-PLAY clears outputs without a clock edge.
        check("pre_rst_run", run, 1);
        #2 rst_n = 1'b0;
        #1 check_zero("async");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Win by the player; extra goals ignored; restart clears everything.
        tick(4'h4, 1'b0, 1'b0, 1'b0);
        go_play();
        tick(4'h0, 1'b0, 1'b1, 1'b0);
        go_play();
        tick(4'h0, 1'b0, 1'b1, 1'b0);
        check("win_score", player_score, 2);
        check("win_over", game_over, 1);
        check("win_winner", winner, 1);
        check("win_run", run, 0);
        tick(4'h0, 1'b1, 1'b1, 1'b0);
        tick(4'h0, 1'b0, 1'b0, 1'b1);
        check("over_pscore", player_score, 2);
        check("over_escore", enemy_score, 0);
        tick(4'h4, 1'b0, 1'b0, 1'b0);
        check("restart_state", state, 1);
        check("restart_pscore", player_score, 0);
        check("restart_over", game_over, 0);
        check("restart_winner", winner, 0);

        // Pause key.
        tick(4'h0, 1'b0, 1'b0, 1'b0);
        go_play();
        tick(4'h8, 1'b0, 1'b0, 1'b0);
`ifdef MATCH_PAUSE_EN
        check("pause_state", state, 5);
        check("pause_run", run, 0);
        tick(4'h8, 1'b0, 1'b1, 1'b0);
        tick(4'h0, 1'b1, 1'b0, 1'b1);
        check("pause_goal_ign", player_score, 0);
        tick(4'h4, 1'b0, 1'b0, 1'b0);
        check("pause_start_ign", state, 5);
        tick(4'h8, 1'b0, 1'b0, 1'b0);
        check("resume_state", state, 2);
        check("resume_run", run, 0);
        tick(4'h0, 1'b0, 1'b0, 1'b0);
        check("resume_run2", run, 1);
`else
        check("nopause_state", state, 2);
        check("nopause_run", run, 1);
        tick(4'h0, 1'b0, 1'b0, 1'b0);
`endif
        tick(4'h8, 1'b0, 1'b1, 1'b0);
        check("goal_beats_pause", state, 3);
        check("goal_beats_pause_sc", player_score, 1);

        // Random play against the model.
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] k;
            k[1:0] = 2'($urandom_range(0, 3));
            k[2]   = ($urandom_range(0, 7) == 0);
            k[3]   = ($urandom_range(0, 5) == 0);
            tick(k, ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
